alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Command initiator for the arithmetic unit. It accepts one operand pair and function code over a valid/ready handshake and drives the ALU inputs with a single-cycle `Arith_enable` pulse. It captures the registered ALU result when `Arith_Flag` returns, then presents the result over a valid/ready response channel with backpressure. It sits between the system command source and the arithmetic unit, and owns all sequencing toward it.

## Interface
- `IN_DATA_WIDTH`, default 16: operand width.
- `OUT_DATA_WIDTH`, default 32: result width; must be ≥ `IN_DATA_WIDTH`+1.
- `TIMEOUT`, default 4: maximum number of WAIT cycles before an error response; must be ≥ 1.

Ports (name, direction, width, meaning):
- `CLK` in 1: the single clock; all logic is on the rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `CMD_VALID` in 1: the command is valid.
- `CMD_READY` out 1: the block can accept a command.
- `CMD_A`, `CMD_B` in `IN_DATA_WIDTH`: operands.
- `CMD_FUNC` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `ALU_A`, `ALU_B` out `IN_DATA_WIDTH`: operands driven to the ALU.
- `ALU_FUNC` out 2: function driven to the ALU.
- `Arith_enable` out 1: ALU enable pulse.
- `Arith_OUT` in `OUT_DATA_WIDTH`: registered ALU result.
- `Carry_OUT` in 1: registered ALU carry.
- `Arith_Flag` in 1: ALU result valid, one cycle after enable.
- `RSP_VALID` out 1: a response is available.
- `RSP_READY` in 1: the consumer accepts the response.
- `RSP_DATA` out `OUT_DATA_WIDTH`: captured result.
- `RSP_CARRY` out 1: captured carry.
- `RSP_ERR` out 1: timeout, or divide-by-zero when the divide-by-zero check is compiled in.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
  - `CMD_READY` rises in the first cycle after `RST` goes high.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `CMD_READY`=1. When `CMD_VALID`&`CMD_READY` at an edge:
  - latch `CMD_A`/`CMD_B`/`CMD_FUNC` into `ALU_A`/`ALU_B`/`ALU_FUNC`;
  - drop `CMD_READY`;
  - go to ISSUE.
- **ISSUE:** `Arith_enable`=1 for exactly one cycle; clear the wait timer; go to WAIT.
- **WAIT:** `Arith_enable`=0.
  - If `Arith_Flag`=1: capture `Arith_OUT`→`RSP_DATA` and `Carry_OUT`→`RSP_CARRY`; set `RSP_ERR`=0; go to RESP.
  - Else, if timer==`TIMEOUT`-1: `RSP_DATA`=0, `RSP_CARRY`=0, `RSP_ERR`=1; go to RESP.
  - Else increment the timer.
- **RESP:** `RSP_VALID`=1, with `RSP_DATA`/`RSP_CARRY`/`RSP_ERR` held stable until `RSP_READY`=1 at an edge.
  - On that edge: `RSP_VALID`→0, `CMD_READY`→1, go to IDLE.
- `ALU_A`/`ALU_B`/`ALU_FUNC` hold their values from the accept until the next accept.
- `Arith_Flag`, `Arith_OUT` and `Carry_OUT` are ignored outside WAIT. This covers stale flags, since the ALU itself has no reset.
- Only one command is in flight at a time. `CMD_READY`=0 in ISSUE, WAIT and RESP.
- `RST` low in any state returns the FSM to IDLE at that edge:
  - `Arith_enable`, `RSP_VALID` and `CMD_READY` go to 0;
  - any in-flight result is discarded and no response is produced.

## Timing
- Accept at edge 0. ISSUE is cycle 1 (`Arith_enable` high), WAIT is cycle 2 (flag sampled), `RSP_VALID` is high from cycle 3.
- Accept-to-`RSP_VALID` latency: 3 cycles.
- Best-case throughput: one command per 4 cycles (RESP handshake in its first cycle, next accept in the following IDLE cycle).
- Timeout path: WAIT lasts `TIMEOUT` cycles, and `RSP_VALID` rises in cycle 2+`TIMEOUT`.
- `RSP_VALID` never drops without a handshake, except on reset.

## Configuration
- Macro: `ALU_DIV_ZERO_CHECK_EN`.
- Defined:
  - An accept in IDLE with `CMD_FUNC`=11 and `CMD_B`=0 goes straight to RESP; `RSP_VALID` rises in cycle 1.
  - Response values: `RSP_DATA` all ones, `RSP_CARRY`=0, `RSP_ERR`=1.
  - `Arith_enable` is never asserted for this command.
- Undefined: the command is issued normally, and the response carries whatever the ALU returns.

## Structure
- Package `alu_pkg` holds:
  - the function code constants `ALU_ADD`/`ALU_SUB`/`ALU_MUL`/`ALU_DIV` (2-bit);
  - the FSM state encoding.
- Sub-module `alu_timeout_counter` is a clear/increment counter of width clog2(`TIMEOUT`)+1 with an `expired` output.

## Test plan
- **Add:** ADD `CMD_A`=0x0005, `CMD_B`=0x0003 → `Arith_enable` high in cycle 1 only; `RSP_VALID` in cycle 3 with `RSP_DATA`=0x00000008, `RSP_CARRY`=0, `RSP_ERR`=0.
- **Carry:** ADD 0xFFFF+0x0001 → `RSP_DATA`=0x00010000, `RSP_CARRY`=1.
- **Backpressure:** MUL 0x0100×0x0100 with `RSP_READY` held low for 5 cycles → `RSP_VALID` and `RSP_DATA`=0x00010000 stable throughout; `CMD_READY`=0 and `CMD_VALID` ignored; IDLE after the handshake.
- **Timeout:** ALU model ties `Arith_Flag`=0, `TIMEOUT`=4 → `RSP_VALID` in cycle 6 with `RSP_ERR`=1, `RSP_DATA`=0.
- **Divide by zero** (`ALU_DIV_ZERO_CHECK_EN` defined): DIV 0x0010/0x0000 → `RSP_VALID` in cycle 1, `RSP_DATA`=0xFFFFFFFF, `RSP_ERR`=1, `Arith_enable` never high.
- **Reset mid-operation:** `RST` low during WAIT → at the next edge all outputs are 0, then `CMD_READY`=1 one cycle after release; a following SUB 0x0009−0x0004 returns 0x00000005.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: function codes,
// FSM state encoding and a small decode helper.
package alu_pkg;

  // Function codes understood by the arithmetic unit
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  // Issuer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } alu_state_e;

  // True when a command would divide by zero
  function automatic logic is_div_zero(input logic [1:0] func, input logic b_is_zero);
    return (func == ALU_DIV) && b_is_zero;
  endfunction

endpackage

// File: rtl/alu_timeout_counter.sv
// Clear/increment wait timer for the ALU command issuer.
// `expired` is high while the count sits at TIMEOUT-1, i.e. on the last
// permitted wait cycle.
module alu_timeout_counter #(
  parameter int TIMEOUT   = 4,
  parameter int CNT_WIDTH = $clog2(TIMEOUT) + 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  // Clear wins over increment; otherwise hold
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command initiator for the arithmetic unit. Accepts one operand pair over
// a valid/ready channel, pulses Arith_enable for one cycle, captures the
// ALU result when Arith_Flag returns (or times out), and presents it on a
// valid/ready response channel with backpressure. All outputs registered.
// Optional feature macro: ALU_DIV_ZERO_CHECK_EN (short-circuits DIV by zero
// to an immediate error response without touching the ALU).
module alu_cmd_issuer #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [IN_DATA_WIDTH-1:0]  CMD_A,
  input  logic [IN_DATA_WIDTH-1:0]  CMD_B,
  input  logic [1:0]                CMD_FUNC,
  output logic [IN_DATA_WIDTH-1:0]  ALU_A,
  output logic [IN_DATA_WIDTH-1:0]  ALU_B,
  output logic [1:0]                ALU_FUNC,
  output logic                      Arith_enable,
  input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
  input  logic                      Carry_OUT,
  input  logic                      Arith_Flag,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [OUT_DATA_WIDTH-1:0] RSP_DATA,
  output logic                      RSP_CARRY,
  output logic                      RSP_ERR
);

  import alu_pkg::*;

  localparam int TIMER_W = $clog2(TIMEOUT) + 1;

  alu_state_e                state_reg, state_next;
  logic                      cmd_ready_reg, cmd_ready_next;
  logic [IN_DATA_WIDTH-1:0]  alu_a_reg, alu_a_next;
  logic [IN_DATA_WIDTH-1:0]  alu_b_reg, alu_b_next;
  logic [1:0]                alu_func_reg, alu_func_next;
  logic                      arith_enable_reg, arith_enable_next;
  logic                      rsp_valid_reg, rsp_valid_next;
  logic [OUT_DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                      rsp_carry_reg, rsp_carry_next;
  logic                      rsp_err_reg, rsp_err_next;

  logic timer_clear;
  logic timer_inc;
  logic timer_expired;
  logic div_zero_hit;

`ifdef ALU_DIV_ZERO_CHECK_EN
  assign div_zero_hit = is_div_zero(CMD_FUNC, (CMD_B == '0));
`else
  assign div_zero_hit = 1'b0;
`endif

  alu_timeout_counter #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (TIMER_W)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // Next-state and next-output decode; every register holds by default
  always_comb begin
    state_next        = state_reg;
    cmd_ready_next    = cmd_ready_reg;
    alu_a_next        = alu_a_reg;
    alu_b_next        = alu_b_reg;
    alu_func_next     = alu_func_reg;
    arith_enable_next = 1'b0;
    rsp_valid_next    = rsp_valid_reg;
    rsp_data_next     = rsp_data_reg;
    rsp_carry_next    = rsp_carry_reg;
    rsp_err_next      = rsp_err_reg;
    timer_clear       = 1'b0;
    timer_inc         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cmd_ready_next = 1'b1;
        if (CMD_VALID && cmd_ready_reg) begin
          alu_a_next     = CMD_A;
          alu_b_next     = CMD_B;
          alu_func_next  = CMD_FUNC;
          cmd_ready_next = 1'b0;
          if (div_zero_hit) begin
            // Never bother the ALU; answer with an error right away
            state_next     = ST_RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = '1;
            rsp_carry_next = 1'b0;
            rsp_err_next   = 1'b1;
          end else begin
            state_next        = ST_ISSUE;
            arith_enable_next = 1'b0;
          end
        end
      end

      ST_ISSUE: begin
        // Enable is high during this state; drop it and start timing
        timer_clear = 1'b1;
        state_next  = ST_WAIT;
      end

      ST_WAIT: begin
        if (Arith_Flag) begin
          rsp_data_next  = Arith_OUT;
          rsp_carry_next = Carry_OUT;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else if (timer_expired) begin
          rsp_data_next  = '0;
          rsp_carry_next = 1'b0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else begin
          timer_inc = 1'b1;
        end
      end

      ST_RESP: begin
        if (RSP_READY) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Enable is registered, so it is launched on the accept edge itself
    if ((state_reg == ST_IDLE) && CMD_VALID && cmd_ready_reg && !div_zero_hit) begin
      arith_enable_next = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg        <= ST_IDLE;
      cmd_ready_reg    <= 1'b0;
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      alu_func_reg     <= '0;
      arith_enable_reg <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_data_reg     <= '0;
      rsp_carry_reg    <= 1'b0;
      rsp_err_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cmd_ready_reg    <= cmd_ready_next;
      alu_a_reg        <= alu_a_next;
      alu_b_reg        <= alu_b_next;
      alu_func_reg     <= alu_func_next;
      arith_enable_reg <= arith_enable_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_data_reg     <= rsp_data_next;
      rsp_carry_reg    <= rsp_carry_next;
      rsp_err_reg      <= rsp_err_next;
    end
  end

  assign CMD_READY    = cmd_ready_reg;
  assign ALU_A        = alu_a_reg;
  assign ALU_B        = alu_b_reg;
  assign ALU_FUNC     = alu_func_reg;
  assign Arith_enable = arith_enable_reg;
  assign RSP_VALID    = rsp_valid_reg;
  assign RSP_DATA     = rsp_data_reg;
  assign RSP_CARRY    = rsp_carry_reg;
  assign RSP_ERR      = rsp_err_reg;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer. Stimulus pushes hand-computed
// expected responses; a monitor checks latency, enable pulses, busy
// behaviour and response contents whenever the DUT presents a response.
module tb_alu_cmd_issuer;

  import alu_pkg::*;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [15:0] CMD_A;
  logic [15:0] CMD_B;
  logic [1:0]  CMD_FUNC;
  logic [15:0] ALU_A;
  logic [15:0] ALU_B;
  logic [1:0]  ALU_FUNC;
  logic        Arith_enable;
  logic [31:0] Arith_OUT;
  logic        Carry_OUT;
  logic        Arith_Flag;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        RSP_CARRY;
  logic        RSP_ERR;

  alu_cmd_issuer #(
    .IN_DATA_WIDTH  (16),
    .OUT_DATA_WIDTH (32),
    .TIMEOUT        (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_A        (CMD_A),
    .CMD_B        (CMD_B),
    .CMD_FUNC     (CMD_FUNC),
    .ALU_A        (ALU_A),
    .ALU_B        (ALU_B),
    .ALU_FUNC     (ALU_FUNC),
    .Arith_enable (Arith_enable),
    .Arith_OUT    (Arith_OUT),
    .Carry_OUT    (Carry_OUT),
    .Arith_Flag   (Arith_Flag),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_DATA     (RSP_DATA),
    .RSP_CARRY    (RSP_CARRY),
    .RSP_ERR      (RSP_ERR)
  );

  typedef struct {
    logic [31:0] data;
    logic        carry;
    logic        err;
    int          lat;
    int          en;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   en_cnt = 0;
  int   rsp_num = 0;
  bit   in_flight = 0;
  bit   pending = 0;
  logic alu_flag_en;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural ALU: registered result and flag one cycle after enable
  always @(posedge CLK) begin
    Arith_Flag <= alu_flag_en && Arith_enable;
    if (Arith_enable) begin
      case (ALU_FUNC)
        2'b00: begin
          Arith_OUT <= {16'h0, ALU_A} + {16'h0, ALU_B};
          Carry_OUT <= ({1'b0, ALU_A} + {1'b0, ALU_B}) >> 16 != 17'h0;
        end
        2'b01: begin
          Arith_OUT <= {16'h0, ALU_A} - {16'h0, ALU_B};
          Carry_OUT <= (ALU_A < ALU_B);
        end
        2'b10: begin
          Arith_OUT <= {16'h0, ALU_A} * {16'h0, ALU_B};
          Carry_OUT <= 1'b0;
        end
        default: begin
          Arith_OUT <= (ALU_B == 16'h0) ? 32'hFFFF_FFFF : {16'h0, ALU_A / ALU_B};
          Carry_OUT <= 1'b0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic c, input logic e, input int lat, input int en);
    exp_t t;
    t.data  = d;
    t.carry = c;
    t.err   = e;
    t.lat   = lat;
    t.en    = en;
    sb.push_back(t);
  endtask

  // Monitor: samples just after the falling edge, stimulus drives on it
  always @(negedge CLK) begin
    #1;
    if (!RST) begin
      in_flight = 0;
      pending   = 0;
    end else begin
      if (Arith_enable) begin
        check("enable_in_flight", {31'h0, in_flight}, 32'h1);
        check("enable_cycle", 32'(cyc - acc_cyc), 32'd1);
        en_cnt++;
      end
      if (in_flight) check("cmd_ready_busy", {31'h0, CMD_READY}, 32'h0);
      if (RSP_VALID) begin
        if (sb.size() == 0) begin
          check("rsp_valid_unexpected", {31'h0, RSP_VALID}, 32'h0);
        end else begin
          cur = sb[0];
          if (!pending) begin
            check("rsp_latency", 32'(cyc - acc_cyc), 32'(cur.lat));
            pending = 1;
          end
          check("rsp_data", RSP_DATA, cur.data);
          check("rsp_carry", {31'h0, RSP_CARRY}, {31'h0, cur.carry});
          check("rsp_err", {31'h0, RSP_ERR}, {31'h0, cur.err});
          if (RSP_READY) begin
            check("enable_count", 32'(en_cnt), 32'(cur.en));
            rsp_num++;
            $display("rsp %0d: data=0x%08h carry=%0b err=%0b cycle=%0d",
                     rsp_num, RSP_DATA, RSP_CARRY, RSP_ERR, cyc - acc_cyc);
            void'(sb.pop_front());
            pending   = 0;
            in_flight = 0;
          end
        end
      end else if (pending) begin
        check("rsp_valid_held", {31'h0, RSP_VALID}, 32'h1);
        pending = 0;
      end
      if (CMD_VALID && CMD_READY) begin
        in_flight = 1;
        acc_cyc   = cyc;
        en_cnt    = 0;
      end
    end
  end

  // Present a command at a falling edge and hold it until accepted
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f);
    int n = 0;
    CMD_A     = a;
    CMD_B     = b;
    CMD_FUNC  = f;
    CMD_VALID = 1'b1;
    while (!CMD_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_accept: CMD_READY never rose, required 1");
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || in_flight) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    @(negedge CLK);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST         = 1'b0;
    CMD_VALID   = 1'b0;
    CMD_A       = '0;
    CMD_B       = '0;
    CMD_FUNC    = '0;
    RSP_READY   = 1'b1;
    alu_flag_en = 1'b1;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_cmd_ready", {31'h0, CMD_READY}, 32'h0);
    check("reset_rsp_valid", {31'h0, RSP_VALID}, 32'h0);
    check("reset_enable", {31'h0, Arith_enable}, 32'h0);
    check("reset_rsp_data", RSP_DATA, 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", {31'h0, CMD_READY}, 32'h1);

    // Add
    push(32'h0000_0008, 1'b0, 1'b0, 3, 1);
    issue(16'h0005, 16'h0003, ALU_ADD);
    wait_done();

    // Carry out of the operand width
    push(32'h0001_0000, 1'b1, 1'b0, 3, 1);
    issue(16'hFFFF, 16'h0001, ALU_ADD);
    wait_done();

    // Backpressure with a competing command held on the input
    RSP_READY = 1'b0;
    push(32'h0001_0000, 1'b0, 1'b0, 3, 1);
    issue(16'h0100, 16'h0100, ALU_MUL);
    CMD_A     = 16'h1234;
    CMD_B     = 16'h0001;
    CMD_FUNC  = ALU_ADD;
    CMD_VALID = 1'b1;
    n = 0;
    while (!RSP_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL bp_wait: RSP_VALID never rose, required 1");
    end
    repeat (5) begin
      @(negedge CLK);
      check("bp_rsp_valid", {31'h0, RSP_VALID}, 32'h1);
      check("bp_alu_a", {16'h0, ALU_A}, 32'h0000_0100);
    end
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLK);
    check("bp_idle_ready", {31'h0, CMD_READY}, 32'h1);
    check("bp_valid_low", {31'h0, RSP_VALID}, 32'h0);
    wait_done();

    // Timeout: ALU never answers
    alu_flag_en = 1'b0;
    push(32'h0, 1'b0, 1'b1, 6, 1);
    issue(16'h0002, 16'h0002, ALU_ADD);
    wait_done();
    alu_flag_en = 1'b1;

    // Divide by zero
`ifdef ALU_DIV_ZERO_CHECK_EN
    push(32'hFFFF_FFFF, 1'b0, 1'b1, 1, 0);
`else
    push(32'hFFFF_FFFF, 1'b0, 1'b0, 3, 1);
`endif
    issue(16'h0010, 16'h0000, ALU_DIV);
    wait_done();

    // Reset in WAIT: the in-flight command must vanish
    alu_flag_en = 1'b0;
    issue(16'h0007, 16'h0001, ALU_ADD);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_cmd_ready", {31'h0, CMD_READY}, 32'h0);
    check("mid_rst_enable", {31'h0, Arith_enable}, 32'h0);
    check("mid_rst_rsp_valid", {31'h0, RSP_VALID}, 32'h0);
    check("mid_rst_rsp_data", RSP_DATA, 32'h0);
    check("mid_rst_rsp_err", {31'h0, RSP_ERR}, 32'h0);
    check("mid_rst_rsp_carry", {31'h0, RSP_CARRY}, 32'h0);
    check("mid_rst_alu_a", {16'h0, ALU_A}, 32'h0);
    check("mid_rst_alu_b", {16'h0, ALU_B}, 32'h0);
    check("mid_rst_alu_func", {30'h0, ALU_FUNC}, 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_ready_release", {31'h0, CMD_READY}, 32'h1);
    repeat (8) @(negedge CLK);
    alu_flag_en = 1'b1;

    // Subtract after recovery
    push(32'h0000_0005, 1'b0, 1'b0, 3, 1);
    issue(16'h0009, 16'h0004, ALU_SUB);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
